matmul_host_sequencer: RTL and testbench
========================================

// Module: matmul_host_sequencer
// PURPOSE
//  Initiator side of the 2x2 matmul core's enable/listo handshake.
//  - Collects operands A and B as a byte stream from the 8-bit pin interface.
//  - Pulses mm_enable to the core and waits for mm_listo.
//  - Captures the packed 16-bit result and returns it as a byte stream with backpressure.
//  - Sits between the TinyTapeout I/O pins and the matmul core.
// PARAMETERS
//  DATA_W      8   byte-stream width
//  MAT_W       16  packed matrix width (2x2 elements of 4 bits)
//  TIMEOUT_CYC 32  max cycles in WAIT before abort (core needs ~15)
// PORTS
//  clk          in   1      clock; all logic on posedge
//  rst          in   1      asynchronous, active-high reset
//  in_valid     in   1      in_data valid this cycle (no ready; sender paces)
//  in_data      in   8      operand byte
//  out_valid    out  1      out_data holds a result byte
//  out_ready    in   1      consumer accepts out_data when out_valid&&out_ready
//  out_data     out  8      result byte
//  busy         out  1      high in START, WAIT, SEND
//  timeout_err  out  1      sticky: last transaction aborted on timeout
//  mm_enable    out  1      one-cycle start pulse to the core
//  mm_matrix_a  out  16     packed operand A to the core
//  mm_matrix_b  out  16     packed operand B to the core
//  mm_result    in   16     packed result from the core
//  mm_listo     in   1      core done strobe; mm_result valid in the same cycle
// BEHAVIOUR
//  Reset: all outputs and internal registers = 0; state = IDLE.
//  - Async assert forces mm_enable=0 and out_valid=0 immediately.
//  - The top level drives the core's active-low reset from ~rst, so both blocks reset together.
//  Packing: element (r,c) occupies bits [4*(2r+c) +: 4].
//  - Byte order is low byte first.
//  - Stream order: A[7:0], A[15:8], B[7:0], B[15:8].
//  States:
//  - IDLE: in_valid -> byte into A[7:0]; clear timeout_err; byte_cnt=1 -> LOAD.
//  - LOAD: each in_valid stores the byte at byte_cnt and increments byte_cnt.
//    After byte_cnt==3 is stored -> START.
//  - START: mm_enable=1 for exactly this cycle; clear timer -> WAIT.
//    Latency: last operand byte accepted at cycle t -> mm_enable high at t+1.
//  - WAIT: timer increments each cycle.
//    - mm_listo=1: res_q <= mm_result -> SEND (out_valid high next cycle).
//    - timer==TIMEOUT_CYC-1 with no listo: timeout_err<=1 -> IDLE.
//    - If listo and the timeout land in the same cycle, listo wins.
//  - SEND: out_valid=1; out_data=res_q byte[out_idx].
//    - out_valid && out_ready: out_idx++.
//    - After byte 1 accepted: out_valid=0, out_idx=0 -> IDLE.
//    - out_valid=0 is combinational with the state change, so it drops the cycle after the final handshake.
//    - out_ready low: out_valid and out_data held stable indefinitely (no timeout in SEND).
//  Boundary rules:
//  - in_valid while busy: byte dropped, no state change.
//  - mm_listo outside WAIT: ignored.
//  - mm_matrix_a/b written only in IDLE/LOAD; stable from START through SEND.
//  - Result arithmetic is the core's: each element is a sum of products modulo 16. This block does not modify data.
//  - No partial-load timeout: LOAD waits indefinitely for the remaining bytes.
//  - Reset mid-transaction discards all partial operands and results.
// STRUCTURE
//  Package matmul_pkg:
//  - constants ELEM_W=4, M_SIZE=2, MAT_W=16, DATA_W=8, BYTES_PER_MAT=2.
//  - typedef enum logic[2:0] seq_state_t {IDLE, LOAD, START, WAIT, SEND}.
//  No sub-module: one FSM plus 2-bit byte_cnt, 1-bit out_idx, 5-bit timer.
// TESTING
//  1. Identity: bytes 01,10,21,43 -> one mm_enable pulse; out bytes 0x21,0x43; timeout_err=0.
//  2. Wrap: A=0x3333, B=0x3333 -> each element (9+9) mod 16 = 2; out bytes 0x22,0x22.
//  3. Backpressure: out_ready low 5 cycles in SEND -> out_valid=1 and out_data=0x21 held; both bytes exactly once.
//  4. Timeout: mm_listo tied 0 -> timeout_err=1 after 32 WAIT cycles, state IDLE, no out_valid;
//     the next in_valid byte clears timeout_err.
//  5. Busy drop: 3 extra in_valid bytes during WAIT -> result unchanged; next transaction loads correctly.
//  6. Reset mid-WAIT: assert rst -> all outputs 0 at once; after release, a full transaction returns correct bytes.

Source files
------------

// File: rtl/matmul_host_sequencer_pkg.sv
// Shared constants and state encoding for the matmul host sequencer.
package matmul_pkg;

    localparam int unsigned ELEM_W        = 4;
    localparam int unsigned M_SIZE        = 2;
    localparam int unsigned MAT_W         = 16;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned BYTES_PER_MAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        SEND
    } seq_state_t;

endpackage

// File: rtl/matmul_host_sequencer_if.sv
// Byte-stream pin interface: operand bytes in (no ready), result bytes out with backpressure.
interface matmul_host_sequencer_if #(
    parameter int unsigned DATA_W = matmul_pkg::DATA_W
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/matmul_host_sequencer.sv
// Loads A/B from the pin byte stream, fires the 2x2 matmul core, and streams the result back.
module matmul_host_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W      = matmul_pkg::DATA_W,
    parameter int unsigned MAT_W       = matmul_pkg::MAT_W,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    matmul_host_sequencer_if.slave  pins,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    mm_enable,
    output logic [MAT_W-1:0]        mm_matrix_a,
    output logic [MAT_W-1:0]        mm_matrix_b,
    input  logic [MAT_W-1:0]        mm_result,
    input  logic                    mm_listo
);

    localparam int unsigned         TIMER_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    seq_state_t         state;
    logic [1:0]         byte_cnt;
    logic               out_idx;
    logic [TIMER_W-1:0] timer;
    logic [MAT_W-1:0]   res_q;
    logic               out_valid_q;

    // Byte mux is gated by out_valid so the pins read zero outside SEND.
    always_comb begin
        pins.out_valid = out_valid_q;
        pins.out_data  = '0;
        if (out_valid_q) begin
            pins.out_data = out_idx ? res_q[DATA_W +: DATA_W] : res_q[0 +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            out_idx     <= 1'b0;
            timer       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            mm_enable   <= 1'b0;
            mm_matrix_a <= '0;
            mm_matrix_b <= '0;
        end else begin
            mm_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (pins.in_valid) begin
                        mm_matrix_a[0 +: DATA_W] <= pins.in_data;
                        timeout_err              <= 1'b0;
                        byte_cnt                 <= 2'd1;
                        state                    <= LOAD;
                    end
                end
                LOAD: begin
                    if (pins.in_valid) begin
                        case (byte_cnt)
                            2'd1:    mm_matrix_a[DATA_W +: DATA_W] <= pins.in_data;
                            2'd2:    mm_matrix_b[0 +: DATA_W]      <= pins.in_data;
                            default: mm_matrix_b[DATA_W +: DATA_W] <= pins.in_data;
                        endcase
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mm_enable <= 1'b1;
                            busy      <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // listo is checked first so a same-cycle timeout loses.
                    if (mm_listo) begin
                        res_q       <= mm_result;
                        out_idx     <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= SEND;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                SEND: begin
                    if (pins.out_ready) begin
                        if (!out_idx) begin
                            out_idx <= 1'b1;
                        end else begin
                            out_idx     <= 1'b0;
                            out_valid_q <= 1'b0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Randomized scoreboard bench for matmul_host_sequencer with a behavioural matmul core model.
module tb_matmul_host_sequencer;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        timeout_err;
    logic        mm_enable;
    logic [15:0] mm_matrix_a;
    logic [15:0] mm_matrix_b;
    logic [15:0] mm_result;
    logic        mm_listo;

    matmul_host_sequencer_if #(.DATA_W(8)) pins ();

    matmul_host_sequencer #(
        .DATA_W(8),
        .MAT_W(16),
        .TIMEOUT_CYC(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pins(pins.slave),
        .busy(busy),
        .timeout_err(timeout_err),
        .mm_enable(mm_enable),
        .mm_matrix_a(mm_matrix_a),
        .mm_matrix_b(mm_matrix_b),
        .mm_result(mm_result),
        .mm_listo(mm_listo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [7:0]  exp_q[$];
    logic [31:0] op_q[$];
    int          core_lat;
    bit          core_on;
    int          epoch;
    int          ready_mode;
    bit          stray_req;
    int          n_en_seen;
    int          n_en_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // 2x2 matrix product on 4-bit elements, element (r,c) at bits 4*(2r+c).
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int ma[2][2];
        int mb[2][2];
        logic [15:0] res;
        res = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                ma[r][c] = int'(a[4*(2*r+c) +: 4]);
                mb[r][c] = int'(b[4*(2*r+c) +: 4]);
            end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                int s;
                s = 0;
                for (int k = 0; k < 2; k++) s += ma[r][k] * mb[k][c];
                res[4*(2*r+c) +: 4] = 4'(s % 16);
            end
        return res;
    endfunction

    // Consumer: out_ready is driven just after each rising edge.
    initial begin
        pins.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pins.out_ready = ($urandom_range(0, 3) != 0);
                1:       pins.out_ready = 1'b0;
                default: pins.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: handshakes pop the scoreboard; unaccepted bytes must stay put.
    initial begin
        logic       pv;
        logic       pacc;
        logic       pe;
        logic [7:0] pd;
        pv = 1'b0; pacc = 1'b0; pe = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0; pacc = 1'b0; pe = 1'b0;
                continue;
            end
            if (pv && !pacc) begin
                check("hold_valid", pins.out_valid, 1);
                check("hold_data", pins.out_data, pd);
            end
            if (mm_enable) begin
                n_en_seen++;
                check("enable_single_cycle", pe, 0);
            end
            if (pins.out_valid && pins.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got byte 0x%0h, expected no output at %0t", pins.out_data, $time);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (pins.out_data !== e) begin
                        n_fail++;
                        $display("FAIL out_byte: got 0x%0h, expected 0x%0h at %0t", pins.out_data, e, $time);
                    end
                end
            end
            pv   = pins.out_valid;
            pacc = pins.out_valid && pins.out_ready;
            pd   = pins.out_data;
            pe   = mm_enable;
        end
    end

    // Core model: answers each enable after core_lat cycles with the matrix product.
    initial begin
        logic [31:0] ops;
        logic [15:0] res;
        int          lat;
        int          ep;
        bit          on;
        mm_listo  = 1'b0;
        mm_result = '0;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (mm_enable) begin
                n_checks++;
                if (op_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL core_unexpected_enable: got enable, expected none at %0t", $time);
                end else begin
                    n_checks--;
                    ops = op_q.pop_front();
                    check("core_matrix_a", mm_matrix_a, ops[31:16]);
                    check("core_matrix_b", mm_matrix_b, ops[15:0]);
                end
                res = ref_mul(mm_matrix_a, mm_matrix_b);
                lat = core_lat;
                ep  = epoch;
                on  = core_on;
                if (on) begin
                    @(posedge clk);
                    for (int i = 1; i < lat; i++) begin
                        if (ep != epoch) break;
                        @(posedge clk);
                    end
                    if (ep == epoch) begin
                        #1;
                        mm_listo  = 1'b1;
                        mm_result = res;
                        @(posedge clk);
                        #1;
                        mm_listo  = 1'b0;
                        mm_result = 16'($urandom);
                    end
                end
            end else if (stray_req) begin
                mm_listo  = 1'b1;
                mm_result = 16'($urandom);
                @(posedge clk);
                #1;
                mm_listo  = 1'b0;
                stray_req = 1'b0;
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        pins.in_valid = 1'b1;
        pins.in_data  = b;
        @(posedge clk);
        #1;
        pins.in_valid = 1'b0;
        pins.in_data  = 8'($urandom);
    endtask

    // Returns at the falling edge after the last operand byte is taken.
    task automatic send_txn(input logic [15:0] a, input logic [15:0] b, input bit expect_out);
        logic [15:0] r;
        r = ref_mul(a, b);
        op_q.push_back({a, b});
        n_en_exp++;
        if (expect_out) begin
            exp_q.push_back(r[7:0]);
            exp_q.push_back(r[15:8]);
        end
        @(posedge clk);
        #1;
        drive_byte(a[7:0]);
        idle_cycles($urandom_range(0, 2));
        drive_byte(a[15:8]);
        idle_cycles($urandom_range(0, 2));
        drive_byte(b[7:0]);
        idle_cycles($urandom_range(0, 2));
        drive_byte(b[15:8]);
        @(negedge clk);
        check("enable_latency", mm_enable, 1);
        check("busy_in_start", busy, 1);
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check(name, (i < 300), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, pins.out_valid, 0);
        check({tag, "_out_data"}, pins.out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_mm_enable"}, mm_enable, 0);
        check({tag, "_mm_matrix_a"}, mm_matrix_a, 0);
        check({tag, "_mm_matrix_b"}, mm_matrix_b, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before 1000000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        n_checks = 0; n_fail = 0;
        core_lat = 12; core_on = 1'b1; epoch = 0; ready_mode = 2;
        stray_req = 1'b0; n_en_seen = 0; n_en_exp = 0;
        rst = 1'b1;
        pins.in_valid = 1'b0;
        pins.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle_cycles(2);

        // Identity A times B returns B.
        send_txn(16'h1001, 16'h4321, 1'b1);
        wait_done("identity_done");
        check("identity_no_timeout", timeout_err, 0);

        // Every element wraps: 9+9 = 18 -> 2; answered on the last legal WAIT cycle.
        core_lat = 32;
        send_txn(16'h3333, 16'h3333, 1'b1);
        wait_done("wrap_done");
        check("wrap_listo_wins", timeout_err, 0);

        // Backpressure holds the first byte.
        core_lat   = 5;
        ready_mode = 1;
        send_txn(16'h1001, 16'h4321, 1'b1);
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pins.out_valid) break;
        end
        check("bp_valid_seen", (i < 100), 1);
        repeat (5) begin
            check("bp_valid_held", pins.out_valid, 1);
            check("bp_data_held", pins.out_data, 8'h21);
            @(negedge clk);
        end
        ready_mode = 2;
        wait_done("bp_done");

        // Core never answers.
        core_on = 1'b0;
        send_txn(16'hA5C3, 16'h1234, 1'b0);
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("timeout_not_yet", timeout_err, 0);
        check("timeout_busy_before", busy, 1);
        @(negedge clk);
        check("timeout_set", timeout_err, 1);
        check("timeout_idle", busy, 0);
        check("timeout_no_valid", pins.out_valid, 0);
        core_on  = 1'b1;
        core_lat = 8;
        send_txn(16'h0110, 16'h2002, 1'b1);
        check("timeout_cleared", timeout_err, 0);
        wait_done("after_timeout_done");

        // Bytes arriving while busy are dropped.
        core_lat = 20;
        send_txn(16'h4213, 16'h7b9e, 1'b1);
        @(posedge clk);
        #1;
        drive_byte(8'hFF);
        drive_byte(8'hEE);
        drive_byte(8'hDD);
        wait_done("busy_drop_done");
        core_lat = 6;
        send_txn(16'h2112, 16'h5005, 1'b1);
        wait_done("busy_drop_next_done");

        // Stray listo in IDLE is ignored.
        stray_req = 1'b1;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stray_req) break;
        end
        check("stray_issued", (i < 20), 1);
        @(negedge clk);
        check("stray_idle_busy", busy, 0);
        check("stray_idle_valid", pins.out_valid, 0);

        // Reset in the middle of WAIT.
        core_lat = 25;
        send_txn(16'hBEEF, 16'hCAFE, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        epoch++;
        exp_q.delete();
        op_q.delete();
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);
        core_lat = 10;
        send_txn(16'h9876, 16'h1357, 1'b1);
        wait_done("after_reset_done");

        // Randomized traffic.
        ready_mode = 0;
        for (int t = 0; t < 20; t++) begin
            core_lat = $urandom_range(1, 32);
            send_txn(16'($urandom), 16'($urandom), 1'b1);
            wait_done("random_done");
        end

        idle_cycles(4);
        check("enable_count", n_en_seen, n_en_exp);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
